// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: round-robin front end that shares one external ALU among
// NREQ requesters, one operation in flight, results tagged with requester id.
module alu_rr_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1,
    parameter int CNTW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*OPW-1:0]   req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [OPW-1:0]        alu_op,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    input  logic [WIDTH-1:0]      alu_y,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_y,
    output logic                  busy,
    output logic [CNTW-1:0]       ops_done
);

    localparam int              LATW     = $clog2(ALU_LAT + 1);
    localparam logic [LATW-1:0] LAT_LOAD = LATW'(ALU_LAT);
    localparam logic [LATW-1:0] LAT_LAST = LATW'(1);
    localparam logic [IDW-1:0]  LAST_ID  = IDW'(NREQ - 1);
    localparam logic [IDW:0]    NREQ_W   = (IDW + 1)'(NREQ);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [IDW-1:0]  ptr;
    logic [LATW-1:0] wait_cnt;

    logic            gnt_any;
    logic [IDW-1:0]  gnt_id;
    logic [IDW:0]    idx_w;
    logic            do_grant;
    logic            do_sample;
    logic            do_hs;

    // Search ptr, ptr+1, ... wrapping at NREQ (works for non-power-of-2).
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx_w   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, ptr} + (IDW + 1)'(k);
            if (idx_w >= NREQ_W) begin
                idx_w = idx_w - NREQ_W;
            end
            if (!gnt_any && req_valid[idx_w[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = idx_w[IDW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state;
        do_grant  = 1'b0;
        do_sample = 1'b0;
        do_hs     = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_any) begin
                    do_grant = 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (wait_cnt == LAT_LAST) begin
                    do_sample = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    do_hs   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant is combinational; suppressed while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            wait_cnt <= '0;
        end else begin
            if (do_grant) begin
                wait_cnt <= LAT_LOAD;
            end else if (state == EXEC) begin
                wait_cnt <= wait_cnt - LAT_LAST;
            end
            if (do_hs) begin
                ptr <= (resp_id == LAST_ID) ? '0 : resp_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_y     <= '0;
            ops_done   <= '0;
        end else begin
            if (do_grant) begin
                alu_op  <= req_op[gnt_id*OPW +: OPW];
                alu_a   <= req_a[gnt_id*WIDTH +: WIDTH];
                alu_b   <= req_b[gnt_id*WIDTH +: WIDTH];
                resp_id <= gnt_id;
            end
            if (do_sample) begin
                resp_y     <= alu_y;
                resp_valid <= 1'b1;
            end
            if (do_hs) begin
                resp_valid <= 1'b0;
                if (ops_done != CNT_MAX) begin
                    ops_done <= ops_done + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed stimulus, transaction-level reference model.
// dut0 uses ALU_LAT=1/CNTW=3, dut1 uses ALU_LAT=3/CNTW=16.
module tb_alu_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   rv  [2];
    logic [11:0]  rop [2];
    logic [255:0] ra  [2];
    logic [255:0] rb  [2];
    logic         rr  [2];
    wire  [3:0]   rdy [2];
    wire  [2:0]   aop [2];
    wire  [63:0]  aa  [2];
    wire  [63:0]  ab  [2];
    wire  [63:0]  ay  [2];
    wire          rsv [2];
    wire  [1:0]   rid [2];
    wire  [63:0]  ry  [2];
    wire          bsy [2];
    wire  [2:0]   ops0;
    wire  [15:0]  ops1;
    logic         glitch;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    int         mt   [2];
    int         mown [2];
    int         mpri [2];
    int         mcnt [2];
    logic [2:0] mop  [2];
    logic [63:0] ma  [2];
    logic [63:0] mb  [2];
    logic [63:0] my  [2];

    int          g_id  [$];
    int          g_cyc [$];
    int          r_id  [$];
    logic [63:0] r_y   [$];
    int          ord5  [5] = '{0, 1, 2, 3, 0};

    function automatic logic [63:0] alu_f(logic [2:0] op, logic [63:0] a,
                                          logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return a + b;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(int d);
        return (d == 0) ? 7 : 65535;
    endfunction

    function automatic int pick(logic [3:0] v, int p);
        int i;
        for (int k = 0; k < 4; k++) begin
            i = (p + k) % 4;
            if (v[i[1:0]]) return i;
        end
        return -1;
    endfunction

    // dut1's ALU output is corrupted on every EXEC cycle but the last one.
    always_comb glitch = (mt[1] >= 1) && (mt[1] < lat(1));

    assign ay[0] = alu_f(aop[0], aa[0], ab[0]);
    assign ay[1] = alu_f(aop[1], aa[1], ab[1]) ^
                   (glitch ? 64'hA5A5_5A5A_0F0F_F0F0 : 64'd0);

    alu_rr_arbiter #(.ALU_LAT(1), .CNTW(3)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_op(rop[0]), .req_a(ra[0]), .req_b(rb[0]),
        .alu_op(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_y(ay[0]),
        .resp_valid(rsv[0]), .resp_ready(rr[0]),
        .resp_id(rid[0]), .resp_y(ry[0]),
        .busy(bsy[0]), .ops_done(ops0)
    );

    alu_rr_arbiter #(.ALU_LAT(3), .CNTW(16)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_op(rop[1]), .req_a(ra[1]), .req_b(rb[1]),
        .alu_op(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_y(ay[1]),
        .resp_valid(rsv[1]), .resp_ready(rr[1]),
        .resp_id(rid[1]), .resp_y(ry[1]),
        .busy(bsy[1]), .ops_done(ops1)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            mt[d] = 0; mown[d] = 0; mpri[d] = 0; mcnt[d] = 0;
            mop[d] = '0; ma[d] = '0; mb[d] = '0; my[d] = '0;
        end
    endtask

    task automatic compare(int d);
        logic [3:0]  er;
        logic [15:0] ops;
        int          g;
        er = '0;
        g = pick(rv[d], mpri[d]);
        if (mt[d] == 0 && !rst && g >= 0) er[g[1:0]] = 1'b1;
        ops = (d == 0) ? {13'd0, ops0} : ops1;
        chk($sformatf("d%0d req_ready", d), 64'(rdy[d]), 64'(er));
        chk($sformatf("d%0d busy", d), 64'(bsy[d]), 64'(mt[d] != 0));
        chk($sformatf("d%0d alu_op", d), 64'(aop[d]), 64'(mop[d]));
        chk($sformatf("d%0d alu_a", d), aa[d], ma[d]);
        chk($sformatf("d%0d alu_b", d), ab[d], mb[d]);
        chk($sformatf("d%0d resp_valid", d), 64'(rsv[d]),
            64'(mt[d] > lat(d)));
        chk($sformatf("d%0d resp_id", d), 64'(rid[d]), 64'(mown[d]));
        chk($sformatf("d%0d resp_y", d), ry[d], my[d]);
        chk($sformatf("d%0d ops_done", d), 64'(ops), 64'(mcnt[d]));
    endtask

    task automatic step(int d);
        int g;
        if (mt[d] == 0) begin
            g = pick(rv[d], mpri[d]);
            if (g >= 0) begin
                mown[d] = g;
                mop[d]  = rop[d][g*3 +: 3];
                ma[d]   = ra[d][g*64 +: 64];
                mb[d]   = rb[d][g*64 +: 64];
                mt[d]   = 1;
            end
        end else if (mt[d] <= lat(d)) begin
            if (mt[d] == lat(d)) my[d] = alu_f(mop[d], ma[d], mb[d]);
            mt[d]++;
        end else if (rr[d]) begin
            if (mcnt[d] < cmax(d)) mcnt[d]++;
            mpri[d] = (mown[d] + 1) % 4;
            mt[d] = 0;
        end
    endtask

    initial begin
        mreset();
        forever begin
            @(negedge clk);
            if (rst) mreset();
            for (int d = 0; d < 2; d++) compare(d);
            for (int i = 0; i < 4; i++) begin
                if (rdy[0][i]) begin
                    g_id.push_back(i);
                    g_cyc.push_back(cyc);
                end
            end
            if (rsv[0] && rr[0]) begin
                r_id.push_back(int'(rid[0]));
                r_y.push_back(ry[0]);
            end
            @(posedge clk);
            cyc++;
            if (rst) mreset();
            else for (int d = 0; d < 2; d++) step(d);
        end
    end

    task automatic set_req(int d, int i, logic [2:0] op, logic [63:0] a,
                           logic [63:0] b);
        rop[d][i*3 +: 3]  = op;
        ra[d][i*64 +: 64] = a;
        rb[d][i*64 +: 64] = b;
    endtask

    task automatic wait_grant(int d, int i);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rdy[d][i]) ok = 1'b1;
        end
        chk($sformatf("d%0d grant wait %0d", d, i), 64'(ok), 64'd1);
    endtask

    task automatic wait_valid(int d);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rsv[d]) ok = 1'b1;
        end
        chk($sformatf("d%0d valid wait", d), 64'(ok), 64'd1);
    endtask

    task automatic wait_resp(int d);
        bit ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (rsv[d] && rr[d]) ok = 1'b1;
        end
        chk($sformatf("d%0d resp wait", d), 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rv[0] = '0; rv[1] = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_op(int d, int i, logic [2:0] op, logic [63:0] a,
                          logic [63:0] b);
        set_req(d, i, op, a, b);
        rv[d][i] = 1'b1;
        wait_grant(d, i);
        @(posedge clk); #1;
        rv[d][i] = 1'b0;
        wait_resp(d);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int m0;
        int cnt;
        for (int d = 0; d < 2; d++) begin
            rv[d] = '0; rop[d] = '0; ra[d] = '0; rb[d] = '0; rr[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", 64'(rdy[d]), 64'd0);
            chk("reset resp_valid", 64'(rsv[d]), 64'd0);
            chk("reset busy", 64'(bsy[d]), 64'd0);
            chk("reset alu_a", aa[d], 64'd0);
            chk("reset resp_y", ry[d], 64'd0);
        end
        chk("reset ops0", 64'(ops0), 64'd0);
        chk("reset ops1", 64'(ops1), 64'd0);
        rst = 1'b0;

        // all four requesters held: strict rotation 0,1,2,3,0
        set_req(0, 0, 3'd3, 64'd1, 64'd2);
        set_req(0, 1, 3'd0, 64'hFF00, 64'h0FF0);
        set_req(0, 2, 3'd2, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        set_req(0, 3, 3'd1, 64'd1, 64'd2);
        n0 = g_id.size();
        m0 = r_id.size();
        rv[0] = 4'hF;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 5; k++) begin
            @(negedge clk);
            if (rdy[0] != 4'd0) cnt++;
        end
        chk("t2 grants seen", 64'(cnt), 64'd5);
        @(posedge clk); #1;
        rv[0] = '0;
        wait_resp(0);
        chk("t2 grant log", 64'(g_id.size() - n0), 64'd5);
        chk("t2 resp log", 64'(r_id.size() - m0), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk("t2 grant order", 64'(g_id[n0+k]), 64'(ord5[k]));
            chk("t2 resp order", 64'(r_id[m0+k]), 64'(ord5[k]));
        end
        for (int k = 0; k < 4; k++)
            chk("t2 spacing", 64'(g_cyc[n0+k+1] - g_cyc[n0+k]), 64'd3);
        chk("t2 y0", r_y[m0], 64'd3);
        chk("t2 y1", r_y[m0+1], 64'h0F00);
        chk("t2 y2", r_y[m0+2], 64'h1DD9_9DD1_1DD9_9DD1);
        chk("t2 ops", 64'(ops0), 64'd5);

        // single XOR request, ALU_LAT=1
        do_reset();
        set_req(0, 0, 3'd2, 64'h0F, 64'hF0);
        rv[0] = 4'b0001;
        @(negedge clk);
        chk("t1 grant", 64'(rdy[0]), 64'b0001);
        @(posedge clk); #1;
        rv[0] = '0;
        chk("t1 exec ready", 64'(rdy[0]), 64'd0);
        chk("t1 exec valid", 64'(rsv[0]), 64'd0);
        @(posedge clk); #1;
        chk("t1 valid", 64'(rsv[0]), 64'd1);
        chk("t1 id", 64'(rid[0]), 64'd0);
        chk("t1 y", ry[0], 64'hFF);
        @(posedge clk); #1;
        chk("t1 ops", 64'(ops0), 64'd1);
        chk("t1 idle", 64'(bsy[0]), 64'd0);

        // response backpressure with a competing request pending
        rr[0] = 1'b0;
        set_req(0, 1, 3'd2, 64'd5, 64'd3);
        set_req(0, 0, 3'd2, 64'h70, 64'h01);
        rv[0] = 4'b0010;
        wait_grant(0, 1);
        @(posedge clk); #1;
        rv[0] = '0;
        wait_valid(0);
        @(posedge clk); #1;
        rv[0] = 4'b0001;
        repeat (5) begin
            @(negedge clk);
            chk("t3 y", ry[0], 64'd6);
            chk("t3 id", 64'(rid[0]), 64'd1);
            chk("t3 ready", 64'(rdy[0]), 64'd0);
            chk("t3 busy", 64'(bsy[0]), 64'd1);
            chk("t3 ops", 64'(ops0), 64'd1);
        end
        @(posedge clk); #1;
        rr[0] = 1'b1;
        @(negedge clk);
        chk("t3 hs no grant", 64'(rdy[0]), 64'd0);
        @(posedge clk); #1;
        chk("t3 ops after", 64'(ops0), 64'd2);
        @(negedge clk);
        chk("t3 late grant", 64'(rdy[0]), 64'b0001);
        @(posedge clk); #1;
        rv[0] = '0;
        wait_resp(0);
        chk("t3 late y", r_y[$], 64'h71);
        chk("t3 late id", 64'(r_id[$]), 64'd0);

        // ALU_LAT=3 with a corrupted ALU result outside the sample cycle
        set_req(1, 3, 3'd1, 64'hF0F0, 64'h0F0F);
        rv[1] = 4'b1000;
        @(negedge clk);
        chk("t4 grant", 64'(rdy[1]), 64'b1000);
        @(posedge clk); #1;
        rv[1] = '0;
        for (int k = 0; k < 3; k++) begin
            chk("t4 alu_a", aa[1], 64'hF0F0);
            chk("t4 alu_op", 64'(aop[1]), 64'd1);
            chk("t4 early valid", 64'(rsv[1]), 64'd0);
            @(posedge clk); #1;
        end
        chk("t4 valid", 64'(rsv[1]), 64'd1);
        chk("t4 y", ry[1], 64'hFFFF);
        chk("t4 id", 64'(rid[1]), 64'd3);
        @(posedge clk); #1;
        chk("t4 ops", 64'(ops1), 64'd1);

        // reset during EXEC discards the operation
        n0 = r_id.size();
        set_req(0, 2, 3'd3, 64'hDEAD, 64'h1);
        rv[0] = 4'b0100;
        wait_grant(0, 2);
        @(posedge clk); #1;
        rv[0] = '0;
        #2 rst = 1'b1;
        #1;
        chk("t5 alu_a", aa[0], 64'd0);
        chk("t5 alu_op", 64'(aop[0]), 64'd0);
        chk("t5 busy", 64'(bsy[0]), 64'd0);
        chk("t5 resp_id", 64'(rid[0]), 64'd0);
        set_req(0, 0, 3'd2, 64'hAA, 64'h0F);
        set_req(0, 3, 3'd0, 64'hAA, 64'h0F);
        rv[0] = 4'b1001;
        @(negedge clk);
        chk("t5 ready in rst", 64'(rdy[0]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5 first grant", 64'(rdy[0]), 64'b0001);
        @(posedge clk); #1;
        rv[0] = 4'b1000;
        wait_grant(0, 3);
        @(posedge clk); #1;
        rv[0] = '0;
        wait_resp(0);
        chk("t5 resp count", 64'(r_id.size() - n0), 64'd2);
        chk("t5 resp0 id", 64'(r_id[n0]), 64'd0);
        chk("t5 resp1 id", 64'(r_id[n0+1]), 64'd3);
        chk("t5 resp1 y", r_y[n0+1], 64'h0A);

        // counter saturation at 2^3-1
        do_reset();
        for (int k = 0; k < 9; k++) begin
            run_op(0, k % 4, 3'd2, '1, '1);
            chk("t6 y", r_y[$], 64'd0);
            chk("t6 ops", 64'(ops0), 64'((k + 1 > 7) ? 7 : k + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one 64-bit ALU datapath (AND/OR/XOR/ADD/...) among NREQ requesters.
- Arbitration is round-robin, with a valid/ready handshake on each request port and on the single response port.
- Latches the winner's opcode and operands, drives them to the external ALU for ALU_LAT cycles, samples the result, and returns it tagged with the requester id.
- Sits between the issue logic and the ALU top level; only one operation is in flight at a time.

Parameters:
- WIDTH, 64, operand/result width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal ceil(log2(NREQ)).
- OPW, 3, ALU opcode width; opcode is passed through, never decoded.
- ALU_LAT, 1, number of cycles the ALU inputs are held before alu_y is sampled (1..8).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept; at most one bit high.
- req_op  in  NREQ*OPW  opcodes; requester i uses slice [i*OPW +: OPW].
- req_a  in  NREQ*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B; same slicing as req_a.
- alu_op  out  OPW  opcode to the shared ALU.
- alu_a  out  WIDTH  operand A to the ALU.
- alu_b  out  WIDTH  operand B to the ALU.
- alu_y  in  WIDTH  ALU result; combinational from alu_*.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  IDW  index of the requester that owns resp_y.
- resp_y  out  WIDTH  registered result.
- busy  out  1  high whenever state is not IDLE.
- ops_done  out  CNTW  saturating count of completed response handshakes.

Behaviour:

Reset (rst=1, async):
- state=IDLE, rr pointer=0, wait counter=0.
- alu_op/alu_a/alu_b=0, resp_valid=0, resp_id=0, resp_y=0, ops_done=0, req_ready=0.
- Reset mid-operation discards the in-flight op; no response is ever produced for it.

FSM states: IDLE, EXEC, RESP.

IDLE:
- Grant g = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod NREQ.
- req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
- req_ready is 0 in every state other than IDLE.
- On the grant edge: capture req_op/a/b[g] into alu_op/alu_a/alu_b, capture g into resp_id, load wait counter with ALU_LAT, go to EXEC.
- No req_valid set: stay in IDLE; alu_* hold their last values.

EXEC:
- alu_* are held stable.
- Wait counter decrements every cycle.
- In the cycle the counter equals 1: resp_y <= alu_y, resp_valid <= 1, go to RESP.
- EXEC therefore lasts exactly ALU_LAT cycles.

RESP:
- resp_valid, resp_id and resp_y are held stable until resp_ready=1.
- On handshake: resp_valid <= 0; ptr <= (resp_id+1) mod NREQ; ops_done increments, saturating at 2^CNTW-1; go to IDLE.
- No grant is issued in the handshake cycle.

Timing:
- Grant at edge 0 -> resp_valid high after edge ALU_LAT+1.
- Minimum issue interval is ALU_LAT+2 cycles.

Requester protocol:
- req_valid is sampled only in IDLE.
- A requester holding req_valid must keep op/a/b stable until it sees req_ready.
- Deasserting req_valid before grant is allowed (request withdrawn).

Arithmetic:
- The block performs no arithmetic on data.
- The ptr increment and the wrap computation are done modulo NREQ, including non-power-of-2 NREQ.

Simultaneous events:
- rst overrides everything.
- req_valid arriving in EXEC or RESP waits for IDLE; none are lost as long as the requester holds valid.

Test Plan:
1. ALU model = XOR, ALU_LAT=1; req0: op=XOR, A=0x000000000000000F, B=0x00000000000000F0; resp_ready=1 -> req_ready[0] high for 1 cycle; resp_valid 2 cycles after grant with resp_id=0, resp_y=0x00000000000000FF; ops_done=1.
2. All four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; each grant spaced ALU_LAT+2 cycles; resp_id follows the same order. Also: A=0x123456789ABCDEF0, B=0x0FEDCBA987654321 on req2 -> resp_y=0x1DD99DD11DD99DD1.
3. Backpressure: resp_ready=0 for 5 cycles while resp_valid=1 -> resp_y/resp_id stable; all req_ready=0; busy=1; ops_done unchanged until the handshake.
4. ALU_LAT=3 -> alu_a/alu_b/alu_op constant for exactly 3 cycles; resp_valid asserted 4 cycles after grant; alu_y changes outside the sampling cycle are not reflected in resp_y.
5. Reset asserted in EXEC after a grant to req2 -> outputs 0 immediately without a clock edge; no response appears; with req0 and req3 valid after release, req0 is granted first (ptr=0).
6. CNTW=3; 9 completed ops with A=B=0xFFFFFFFFFFFFFFFF (XOR) -> every resp_y=0; ops_done saturates at 7 and holds.
